// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Scans a 4x3 keypad matrix. It drives one row at a time (one-hot) and
//   samples the columns through a 2-flop synchronizer. A key press or a key
//   release is accepted only after DEBOUNCE matching scan ticks. Each accepted
//   press appears once in a one-entry valid/ready output register.
// Ports
//   clk        system clock
//   init_n     asynchronous active-low reset
//   col[2:0]   raw column lines, active-high, asynchronous to clk
//   row[3:0]   one-hot row drive, active-high
//   key_code   0-9 digit, 10 '*', 11 '#', 15 none
//   key_valid  key_code holds an unconsumed key
//   key_ready  consumer takes key_code on an edge where key_valid=1
//   key_held   a debounced key is currently pressed
//   overflow   sticky, set when a key is dropped because the output was full
module keypad_scan_ctrl #(
   parameter int SCAN_DIV = 100000,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       init_n,
   input  logic [2:0] col,
   output logic [3:0] row,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       key_held,
   output logic       overflow
);

   localparam int CW = $clog2(SCAN_DIV);

   typedef enum logic [1:0] {S_SCAN, S_DEB, S_HELD} state_t;

   state_t        state, state_nx;
   logic [2:0]    col_m, col_s;
   logic [CW-1:0] cnt;
   logic          tick;
   logic [2:0]    cand_col;
   logic [3:0]    cand_code;
   logic [3:0]    dcnt, dcnt_inc, dcnt_nx;
   logic [1:0]    ridx;
   logic [3:0]    scan_code, commit_code;
   logic          one_hot, rotate, latch, commit, release_key;

   // Row and column position to key code.
   function automatic logic [3:0] code_of(input logic [1:0] r, input logic [2:0] c);
      logic [1:0] ci;
      ci = c[0] ? 2'd0 : (c[1] ? 2'd1 : 2'd2);
      if (r == 2'd3)
         code_of = (ci == 2'd0) ? 4'd10 : ((ci == 2'd1) ? 4'd0 : 4'd11);
      else
         code_of = 4'({2'b00, r} * 4'd3 + {2'b00, ci} + 4'd1);
   endfunction

   assign tick      = (cnt == CW'(SCAN_DIV - 1));
   assign ridx      = {row[3] | row[2], row[3] | row[1]};
   assign one_hot   = (col_s == 3'b001) || (col_s == 3'b010) || (col_s == 3'b100);
   assign scan_code = code_of(ridx, col_s);
   assign dcnt_inc  = dcnt + 4'd1;

   // Synchronizer and slot counter. The counter runs in every state.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         col_m <= '0;
         col_s <= '0;
         cnt   <= '0;
      end else begin
         col_m <= col;
         col_s <= col_m;
         cnt   <= tick ? '0 : cnt + CW'(1);
      end
   end

   // State register
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) state <= S_SCAN;
      else         state <= state_nx;
   end

   // Next-state logic. All transitions happen on scan ticks.
   always_comb begin
      state_nx = state;
      if (tick) begin
         case (state)
            S_SCAN: if (one_hot) state_nx = (DEBOUNCE == 1) ? S_HELD : S_DEB;
            S_DEB: begin
               if (col_s != cand_col)         state_nx = S_SCAN;
               else if (dcnt_inc == 4'(DEBOUNCE)) state_nx = S_HELD;
            end
            S_HELD: if (col_s == 3'b000 && dcnt_inc == 4'(DEBOUNCE)) state_nx = S_SCAN;
            default: state_nx = S_SCAN;
         endcase
      end
   end

   // Control strobes. dcnt counts matching ticks in S_DEB and zero ticks in
   // S_HELD, so it is cleared whenever a state is entered.
   always_comb begin
      rotate      = 1'b0;
      latch       = 1'b0;
      commit      = 1'b0;
      release_key = 1'b0;
      commit_code = cand_code;
      dcnt_nx     = dcnt;
      if (tick) begin
         case (state)
            S_SCAN: begin
               if (one_hot) begin
                  latch   = 1'b1;
                  dcnt_nx = 4'd1;
                  if (DEBOUNCE == 1) begin
                     commit      = 1'b1;
                     commit_code = scan_code;
                     dcnt_nx     = 4'd0;
                  end
               end else begin
                  rotate = 1'b1;  // idle or multi-key: keep scanning
               end
            end
            S_DEB: begin
               if (col_s == cand_col) begin
                  dcnt_nx = dcnt_inc;
                  if (dcnt_inc == 4'(DEBOUNCE)) begin
                     commit  = 1'b1;
                     dcnt_nx = 4'd0;
                  end
               end else begin
                  rotate  = 1'b1;
                  dcnt_nx = 4'd0;
               end
            end
            S_HELD: begin
               if (col_s == 3'b000) begin
                  dcnt_nx = dcnt_inc;
                  if (dcnt_inc == 4'(DEBOUNCE)) begin
                     release_key = 1'b1;
                     rotate      = 1'b1;
                     dcnt_nx     = 4'd0;
                  end
               end else begin
                  dcnt_nx = 4'd0;
               end
            end
            default: dcnt_nx = 4'd0;
         endcase
      end
   end

   // Datapath: row drive, candidate latch and the output register.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         row       <= 4'b0001;
         cand_col  <= '0;
         cand_code <= 4'd15;
         dcnt      <= '0;
         key_code  <= 4'd15;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         dcnt <= dcnt_nx;
         if (rotate) row <= {row[2:0], row[3]};
         if (latch) begin
            cand_col  <= col_s;
            cand_code <= scan_code;
         end
         if (commit) begin
            key_held <= 1'b1;
            if (!key_valid || key_ready) begin
               key_code  <= commit_code;
               key_valid <= 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
            key_code  <= 4'd15;
         end
         if (release_key) key_held <= 1'b0;
      end
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl
//   Directed bench for keypad_scan_ctrl with SCAN_DIV=4 and DEBOUNCE=2.
//   A behavioural model is stepped on every falling edge and compared with
//   the outputs. Hand-computed literal checks pin the key timing points.
module tb_keypad_scan_ctrl;

   localparam int SD = 4;
   localparam int DB = 2;

   logic       clk = 1'b0;
   logic       init_n = 1'b0;
   logic [2:0] col = 3'b000;
   logic [3:0] row;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready = 1'b0;
   logic       key_held;
   logic       overflow;

   int tests = 0;
   int fails = 0;

   keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
      .clk(clk), .init_n(init_n), .col(col), .row(row),
      .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
      .key_held(key_held), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int keymap [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};
   logic [2:0] m_s1, m_s2, m_cand;
   int m_pos, m_ridx, m_mode, m_run, m_kc;
   bit m_kv, m_held, m_ovf;

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_cand = 0;
      m_pos = 0; m_ridx = 0; m_mode = 0; m_run = 0; m_kc = 15;
      m_kv = 0; m_held = 0; m_ovf = 0;
   endtask

   // One clock edge. mode: 0 scanning, 1 confirming a press, 2 key down.
   task automatic model_step();
      bit tk, commit, rot;
      int ci;
      tk = (m_pos == SD - 1);
      commit = 0;
      rot = 0;
      if (tk) begin
         if (m_mode == 0) begin
            if ($countones(m_s2) == 1) begin
               m_cand = m_s2;
               m_run = 1;
               if (m_run == DB) begin commit = 1; m_mode = 2; m_run = 0; end
               else m_mode = 1;
            end else rot = 1;
         end else if (m_mode == 1) begin
            if (m_s2 == m_cand) begin
               m_run++;
               if (m_run == DB) begin commit = 1; m_mode = 2; m_run = 0; end
            end else begin
               m_mode = 0; rot = 1; m_run = 0;
            end
         end else begin
            if (m_s2 == 0) begin
               m_run++;
               if (m_run == DB) begin m_held = 0; m_mode = 0; rot = 1; m_run = 0; end
            end else m_run = 0;
         end
      end
      ci = m_cand[0] ? 0 : (m_cand[1] ? 1 : 2);
      if (commit) begin
         m_held = 1;
         if (!m_kv || key_ready) begin m_kc = keymap[m_ridx][ci]; m_kv = 1; end
         else m_ovf = 1;
      end else if (m_kv && key_ready) begin
         m_kv = 0; m_kc = 15;
      end
      if (rot) m_ridx = (m_ridx + 1) % 4;
      m_pos = (m_pos + 1) % SD;
      m_s2 = m_s1;
      m_s1 = col;
   endtask

   // Model step and compare on every falling edge. Inputs only change 1ns
   // after a falling edge, so the inputs seen here are the inputs the
   // preceding rising edge sampled.
   initial begin
      logic [3:0] exp_row;
      model_reset();
      forever begin
         @(negedge clk);
         if (!init_n) model_reset();
         else model_step();
         exp_row = 4'(1 << m_ridx);
         tests++;
         if (row !== exp_row || key_code !== 4'(m_kc) || key_valid !== m_kv ||
             key_held !== m_held || overflow !== m_ovf) begin
            fails++;
            $display("FAIL cycle_cmp t=%0t row=%b exp %b code=%0d exp %0d valid=%b exp %b held=%b exp %b ovf=%b exp %b",
                     $time, row, exp_row, key_code, m_kc, key_valid, m_kv, key_held, m_held, overflow, m_ovf);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic check(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s got %0d expected %0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic wait_row(input string nm, input logic [3:0] r, input int budget);
      int n = 0;
      while (row !== r && n < budget) begin step(1); n++; end
      if (row !== r) begin
         tests++; fails++;
         $display("FAIL %s timeout row=%b expected %b", nm, row, r);
      end
   endtask

   task automatic wait_held(input string nm, input bit v, input int budget);
      int n = 0;
      while (key_held !== v && n < budget) begin step(1); n++; end
      if (key_held !== v) begin
         tests++; fails++;
         $display("FAIL %s timeout key_held=%b expected %b", nm, key_held, v);
      end
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      // 1: reset and idle scanning, each row held SD cycles
      step(2);
      check("rst_row", int'(row), 1);
      check("rst_code", int'(key_code), 15);
      check("rst_valid", int'(key_valid), 0);
      check("rst_ovf", int'(overflow), 0);
      init_n = 1'b1;
      step(4);
      check("scan_row1", int'(row), 2);
      step(3);
      check("scan_row1_hold", int'(row), 2);
      step(1);
      check("scan_row2", int'(row), 4);
      step(32);
      check("idle_valid", int'(key_valid), 0);

      // 2: press '5', key_ready low
      wait_row("t2_row", 4'b0010, 20);
      col = 3'b010;
      step(4);
      check("t2_deb_valid", int'(key_valid), 0);
      step(4);
      check("t2_valid", int'(key_valid), 1);
      check("t2_code", int'(key_code), 5);
      check("t2_row_frozen", int'(row), 2);
      col = 3'b000;
      step(4);
      check("t2_held_1zero", int'(key_held), 1);
      step(4);
      check("t2_released", int'(key_held), 0);
      check("t2_row_after", int'(row), 4);
      check("t2_code_kept", int'(key_code), 5);
      key_ready = 1'b1;
      step(1);
      key_ready = 1'b0;
      check("t2_consumed", int'(key_valid), 0);
      check("t2_code_none", int'(key_code), 15);

      // 3: press '#' with key_ready held high
      key_ready = 1'b1;
      wait_row("t3_row", 4'b1000, 40);
      col = 3'b100;
      step(8);
      check("t3_valid", int'(key_valid), 1);
      check("t3_code", int'(key_code), 11);
      step(1);
      check("t3_valid_drop", int'(key_valid), 0);
      check("t3_code_none", int'(key_code), 15);
      col = 3'b000;
      wait_held("t3_release", 1'b0, 40);
      key_ready = 1'b0;

      // 4: press 7, leave it unconsumed, press 9 -> overflow
      wait_row("t4_row7", 4'b0100, 40);
      col = 3'b001;
      step(8);
      check("t4_code7", int'(key_code), 7);
      col = 3'b000;
      wait_held("t4_rel7", 1'b0, 40);
      wait_row("t4_row9", 4'b0100, 40);
      col = 3'b100;
      step(8);
      check("t4_held9", int'(key_held), 1);
      check("t4_code_kept", int'(key_code), 7);
      check("t4_ovf", int'(overflow), 1);
      col = 3'b000;
      wait_held("t4_rel9", 1'b0, 40);
      key_ready = 1'b1;
      step(1);
      key_ready = 1'b0;
      check("t4_consumed", int'(key_valid), 0);
      check("t4_code_none", int'(key_code), 15);
      check("t4_ovf_sticky", int'(overflow), 1);

      // 5: single-tick bounce, then a two-key chord
      wait_row("t5_row", 4'b0001, 40);
      col = 3'b001;
      step(4);
      col = 3'b000;
      step(4);
      check("t5_bounce_row", int'(row), 2);
      check("t5_bounce_valid", int'(key_valid), 0);
      check("t5_bounce_held", int'(key_held), 0);
      col = 3'b011;
      step(16);
      check("t5_multi_valid", int'(key_valid), 0);
      check("t5_multi_held", int'(key_held), 0);
      col = 3'b000;

      // 6: reset while a key is held and valid, then re-detection
      wait_row("t6_row", 4'b0001, 40);
      col = 3'b001;
      step(8);
      check("t6_code1", int'(key_code), 1);
      check("t6_held", int'(key_held), 1);
      step(1);
      init_n = 1'b0;
      #1;
      check("t6_rst_row", int'(row), 1);
      check("t6_rst_code", int'(key_code), 15);
      check("t6_rst_valid", int'(key_valid), 0);
      check("t6_rst_held", int'(key_held), 0);
      check("t6_rst_ovf", int'(overflow), 0);
      step(1);
      init_n = 1'b1;
      step(7);
      check("t6_not_yet", int'(key_valid), 0);
      step(1);
      check("t6_redetect", int'(key_valid), 1);
      check("t6_redetect_code", int'(key_code), 1);
      col = 3'b000;
      wait_held("t6_release", 1'b0, 40);
      step(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Hard stop so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequences the 4x3 keypad matrix that feeds the safe FSM: drives one-hot rows, samples columns, debounces, and decodes exactly one key per press.
- Presents each key through a one-entry valid/ready output register, with a sticky overflow flag.
- Sits between the board keypad pins and the safe controller.
- Replaces the free-running row demux, which derived the rows from the column inputs themselves.

Parameters:
SCAN_DIV, 100000, clk cycles per row slot; the scan tick fires on the last cycle of each slot (legal values 2 and above).
DEBOUNCE, 4, number of consecutive identical scan ticks required to accept a press or a release (legal values 1 to 15).

Ports:
clk  in  1  system clock
init_n  in  1  asynchronous active-low reset
col  in  3  raw column lines, active-high, asynchronous to clk
row  out  4  one-hot row drive, active-high
key_code  out  4  0-9 = digit, 10 = '*', 11 = '#', 15 = none
key_valid  out  1  key_code holds an unconsumed key
key_ready  in  1  consumer accepts key_code on a clk edge where key_valid=1
key_held  out  1  a debounced key is currently pressed
overflow  out  1  sticky: a key was dropped because the output register was full

Behaviour:
- Reset (init_n=0, asynchronous, any state):
  - row=0001, key_code=15, key_valid=0, key_held=0, overflow=0.
  - State=SCAN; slot counter, debounce counter and synchronizer flops cleared.
- col passes through a 2-flop synchronizer; all decisions use the synchronized value colS.
- Slot counter counts 0..SCAN_DIV-1 and wraps; tick=1 when the count is SCAN_DIV-1. The counter runs in every state.
- Key map (row index, col index -> code):
  - r0: 1, 2, 3
  - r1: 4, 5, 6
  - r2: 7, 8, 9
  - r3: 10, 0, 11
- SCAN:
  - On tick with colS=000: row rotates 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  - On tick with colS one-hot: latch the candidate (row, col), debounce count=1, go to DEBOUNCE. row frozen.
  - On tick with colS having 2 or more bits set: stay in SCAN and rotate (multi-key is ignored).
- DEBOUNCE (row frozen), evaluated on tick:
  - colS equals the latched candidate: count+1. When count reaches DEBOUNCE, commit the key and go to HELD.
  - Any other colS: go to SCAN, rotate the row, no commit.
  - With DEBOUNCE=1, the commit occurs on the same tick as detection in SCAN.
- HELD (row frozen, key_held=1), evaluated on tick:
  - colS=000: count the consecutive zero ticks; reaching DEBOUNCE -> key_held=0, go to SCAN, rotate the row.
  - Any nonzero colS resets the release count; no second commit occurs.
- Commit (registered on the tick edge, so outputs change on the edge that evaluates the qualifying tick):
  - key_valid=0 or key_ready=1: key_code=code, key_valid=1, key_held=1.
  - key_valid=1 and key_ready=0: new key dropped, overflow=1, key_code/key_valid unchanged, key_held=1.
- Handshake:
  - On a clk edge with key_valid=1 and key_ready=1 and no commit: key_valid=0, key_code=15.
  - key_ready is ignored while key_valid=0.
  - key_code is stable whenever key_valid=1.
- overflow is cleared only by init_n.
- Reset asserted mid-press: all state discarded. After release of reset, scanning restarts at row 0001, and a still-held key is re-detected as a new press.
- row is registered, always exactly one-hot, and never 0000.

Test Plan:
(All scenarios use SCAN_DIV=4, DEBOUNCE=2.)
1. Reset, col=000 for 40 cycles -> row cycles 0001/0010/0100/1000 with each value held 4 cycles; key_valid=0, key_code=15.
2. Hold col=010 only while row=0010, key_ready=0 -> key_valid=1, key_code=5 on the 2nd matching tick; row frozen at 0010; key_held=1 until 2 zero ticks after release.
3. Press '#' (row 1000, col 100) with key_ready=1 held high -> key_code=11 and key_valid=1 for exactly one cycle, then key_code=15.
4. Press 7, leave key_ready=0, release, press 9 -> key_code stays 7, overflow=1. Then pulse key_ready for 1 cycle -> key_valid=0, key_code=15.
5. Bounce: col=001 on row 0001 for 1 tick then 000 -> no commit; state returns to SCAN and row advances to 0010. Separately, col=011 on any row -> no commit.
6. Assert init_n=0 for 1 cycle while in HELD with key_valid=1 -> all outputs at reset values immediately. Key still held -> re-detected, key_valid=1 again after 2 ticks on its row.
